// File: rtl/watch_disp_pkg.sv
// Shared definitions for the stopwatch display scanner: field select codes,
// snapshot FSM states, segment constants and the binary-to-decimal split.
package watch_disp_pkg;

    localparam logic [1:0] FIELD_SEC = 2'b00;
    localparam logic [1:0] FIELD_MIN = 2'b01;
    localparam logic [1:0] FIELD_HR  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_SEC,
        RD_MIN,
        RD_HR,
        VERIFY,
        COMMIT
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [3:0] DIGIT_DASH = 4'hF;
    localparam logic [5:0] FIELD_MAX  = 6'd59;

    // Split a 6-bit field into {tens, ones}; values above 59 become two dashes.
    function automatic logic [7:0] split_decimal(input logic [5:0] val);
        logic [3:0] tens;
        logic [3:0] ones;
        if (val > FIELD_MAX) begin
            tens = DIGIT_DASH;
            ones = DIGIT_DASH;
        end else begin
            if (val >= 6'd50)      tens = 4'd5;
            else if (val >= 6'd40) tens = 4'd4;
            else if (val >= 6'd30) tens = 4'd3;
            else if (val >= 6'd20) tens = 4'd2;
            else if (val >= 6'd10) tens = 4'd1;
            else                   tens = 4'd0;
            ones = 4'(val - 6'(tens) * 6'd10);
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational decimal digit to active-low 7-segment pattern.
// Codes 0-9 show the numeral; DIGIT_DASH (and any other code) shows a dash.
module seg7_encode
    import watch_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Lookup of the segment pattern for the selected digit
    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/watch_display_scan.sv
// Six-digit multiplexed HH MM SS display driver for the stopwatch.
// Once per frame a snapshot FSM reads seconds, minutes and hours through the
// shared field-select port, re-reads seconds to detect a wrap during the
// read, and only then copies the three values into the display buffer.
module watch_display_scan
    import watch_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [1:0] field_sel,
    input  logic [5:0] field_val,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [2:0]    DIGIT_LAST = 3'd5;

    state_t        state;
    logic [5:0]    sec_cap, min_cap, hr_cap;
    logic [5:0]    buf_sec, buf_min, buf_hr;
    logic          valid;
    logic          en_q;
    logic [CW-1:0] refresh_cnt;
    logic [2:0]    digit;

    logic          terminal;
    logic          frame_wrap;
    logic [5:0]    cur_field;
    logic [7:0]    cur_split;
    logic [3:0]    cur_digit;
    logic [6:0]    seg_next;

    assign terminal   = (refresh_cnt == CNT_LAST);
    assign frame_wrap = valid && terminal && (digit == DIGIT_LAST);

    // Snapshot FSM: field reads, wrap check and atomic buffer commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            field_sel <= FIELD_SEC;
            sec_cap   <= '0;
            min_cap   <= '0;
            hr_cap    <= '0;
            buf_sec   <= '0;
            buf_min   <= '0;
            buf_hr    <= '0;
            valid     <= 1'b0;
            en_q      <= 1'b0;
        end else if (!enable) begin
            // Buffer contents are kept, but nothing is shown until a new commit
            state     <= IDLE;
            field_sel <= FIELD_SEC;
            valid     <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            en_q <= 1'b1;
            case (state)
                IDLE: begin
                    field_sel <= FIELD_SEC;
                    if (!en_q || frame_wrap) begin
                        state <= RD_SEC;
                    end
                end
                RD_SEC: begin
                    sec_cap   <= field_val;
                    field_sel <= FIELD_MIN;
                    state     <= RD_MIN;
                end
                RD_MIN: begin
                    min_cap   <= field_val;
                    field_sel <= FIELD_HR;
                    state     <= RD_HR;
                end
                RD_HR: begin
                    hr_cap    <= field_val;
                    field_sel <= FIELD_SEC;
                    state     <= VERIFY;
                end
                VERIFY: begin
                    // A smaller second count means seconds rolled over while
                    // minutes/hours were being read: the set may be torn.
                    field_sel <= FIELD_SEC;
                    if (field_val < sec_cap) begin
                        state <= RD_SEC;
                    end else begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    buf_sec   <= sec_cap;
                    buf_min   <= min_cap;
                    buf_hr    <= hr_cap;
                    valid     <= 1'b1;
                    field_sel <= FIELD_SEC;
                    state     <= IDLE;
                end
                default: begin
                    field_sel <= FIELD_SEC;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Refresh divider and digit index; frozen at digit 0 until the buffer is valid
    always_ff @(posedge clk) begin
        if (rst || !enable || !valid) begin
            refresh_cnt <= '0;
            digit       <= '0;
        end else if (terminal) begin
            refresh_cnt <= '0;
            digit       <= (digit == DIGIT_LAST) ? 3'd0 : digit + 3'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    // Pick the buffered field and decimal position for the current digit
    always_comb begin
        cur_field = buf_hr;
        case (digit[2:1])
            2'd0:    cur_field = buf_sec;
            2'd1:    cur_field = buf_min;
            default: cur_field = buf_hr;
        endcase
        cur_split = split_decimal(cur_field);
        cur_digit = digit[0] ? cur_split[7:4] : cur_split[3:0];
    end

    seg7_encode u_seg7_encode (
        .digit (cur_digit),
        .seg   (seg_next)
    );

    // Registered display outputs, blanked while disabled or without a valid buffer
    always_ff @(posedge clk) begin
        if (rst || !enable || !valid) begin
            seg <= SEG_OFF;
            an  <= 6'h3F;
            dp  <= 1'b1;
        end else begin
            seg <= seg_next;
            an  <= ~(6'd1 << digit);
            dp  <= !((digit == 3'd2) || (digit == 3'd4));
        end
    end

endmodule

// File: doc/watch_display_scan.md
# watch_display_scan

Reads the stopwatch's time fields through its field-select/field-value port and drives a 6-digit, multiplexed, common-anode 7-segment display as HH MM SS. Each refresh frame it takes a coherent snapshot of seconds, minutes and hours, so no torn time is ever shown. It converts each 6-bit binary field to two decimal digits and scans the digits at a fixed rate. It sits between the stopwatch top and the board display pins.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays lit; legal range ≥ 8.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  display on when 1; blanked and idle when 0.
- field_sel  out  2  drives the stopwatch `in` select: 00 = seconds, 01 = minutes, 10 = hours; 11 is never driven.
- field_val  in  6  the stopwatch `out`; combinational function of field_sel.
- seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- an  out  6  active-low one-hot digit enables:
  - [0] sec ones, [1] sec tens
  - [2] min ones, [3] min tens
  - [4] hr ones, [5] hr tens
- dp  out  1  active-low decimal point; lit on digits 2 and 4 only, as separators.

## Operation
- **Snapshot FSM states:** IDLE, RD_SEC, RD_MIN, RD_HR, VERIFY, COMMIT.
- **Field reads:** in each RD_*/VERIFY state, field_sel (registered) holds that state's code. field_val is sampled at the end of the same cycle.
- **Sequence:**
  - RD_SEC → RD_MIN → RD_HR → VERIFY. VERIFY re-reads seconds.
  - If verify_sec < first sec (seconds wrapped mid-read), go to RD_SEC and retry.
  - Otherwise go to COMMIT: the three captured values are copied atomically into the display buffer, then the FSM returns to IDLE.
- **Snapshot start:** when digit index wraps 5 → 0, and on the first cycle after enable is high following reset or after enable was low.
- **Buffer:** until COMMIT, the display shows the previous buffer contents.
- **Digit split:** tens = val / 10, ones = val % 10.
- **Out-of-range values:** any field value > 59 shows both of its digits as a dash (segment g only).
- **Segment encoding (active-low):** 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, dash=0x3F.
- **enable = 0:**
  - an=0x3F, seg=0x7F, dp=1, field_sel=00.
  - FSM forced to IDLE; refresh counter and digit index cleared.
  - Buffer retained, but marked not-valid.
- **While buffer is not-valid:** an stays 0x3F. The first COMMIT sets valid, and display begins at digit 0.

## Timing
- **Reset values:** field_sel=00, seg=0x7F, an=0x3F, dp=1, buffer=0, valid=0, digit=0, refresh counter=0, FSM=IDLE.
- **After reset:** with enable=1, RD_SEC begins the first cycle after rst deasserts.
- **Snapshot latency:** 5 cycles best case (4 reads + COMMIT); each retry adds 4 cycles. Seconds wrap at most once per second, so at most one retry occurs per snapshot.
- **Refresh counter:** counts 0 .. REFRESH_DIV-1. At the terminal count, the digit index advances (5 wraps to 0).
  - Each an value is held exactly REFRESH_DIV cycles.
  - One full frame is 6·REFRESH_DIV cycles.
- **Output registers:** seg, an and dp are registered and change together, one cycle after the digit index or buffer changes.
- **Commit effect:** a COMMIT in the middle of a digit changes seg on the next cycle. an is unaffected.
- **Reset priority:** rst dominates enable. rst mid-snapshot aborts it, with no partial commit.
- **enable falling mid-snapshot:** aborts with no commit.

## Structure
- **Package `watch_disp_pkg`:**
  - FIELD_SEC / FIELD_MIN / FIELD_HR codes.
  - FSM state enum.
  - SEG_DASH and SEG_OFF constants.
  - DIGIT_DASH = 4'hF.
- **Sub-module `seg7_encode`:** combinational 4-bit digit (0–9, 4'hF = dash) → 7-bit active-low segments.
- **Top:** FSM, snapshot registers, buffer, divide/modulo-by-10 logic, refresh counter and digit mux.

## Test plan
- **Basic display:** REFRESH_DIV=8, watch model at 12:34:56, reset then enable=1.
  - Digit 0: an=0x3E, seg=0x02.
  - Digit 5: an=0x1F, seg=0x79.
  - dp=0 only when an=0x3B or an=0x2F.
- **Tear avoidance:** model reads sec=59 at RD_SEC, then ticks to 12:35:00 before VERIFY.
  - The FSM must retry.
  - The display shows 12:35:00 and never shows 12:35:59 or 12:34:00.
- **Out-of-range field:** min field=61. an=0x3B and an=0x37 both give seg=0x3F; other digits are unaffected.
- **Enable toggling:** drop enable mid-frame → next cycle an=0x3F, seg=0x7F, field_sel=00.
  - Re-raise it → an stays 0x3F until COMMIT, then digit 0 is shown for 8 cycles.
- **Reset mid-snapshot:** assert rst during RD_MIN → next cycle all reset values, buffer=0, valid=0.
- **Scan timing:** each an value is held exactly 8 cycles and the sequence repeats every 48 cycles. A snapshot starts on each 5 → 0 wrap, visible as field_sel stepping 00, 01, 10, 00.
